// File: rtl/scan_shift_engine.sv
// -----------------------------------------------------------------------------
// scan_shift_engine
//
// Moves snapshot words from a memory-read stream into a serial scan chain and
// collects the bits shifted out of the chain into words on a memory-write
// stream. A single start request shifts `length` chain bits. Each input word
// feeds up to DATA_W shifts, and each output word holds the bits captured
// during those shifts.
//
// Parameters
//   DATA_W  word width of both streams (default 32)
//   LEN_W   width of the chain-length field (default 16)
//
// Ports
//   aclk            clock, rising edge
//   aresetn         asynchronous reset, active-high
//   start, length   begin an operation of `length` bits (ignored unless idle)
//   busy, done      operation in progress / one-cycle completion pulse
//   s_data/valid/ready   words to inject into the chain
//   m_data/valid/ready   captured words from the chain
//   scan_enable     chain in scan mode (equals busy)
//   scan_ck_enable  shift strobe, high only while shifting
//   scan_input      serial data into the chain
//   scan_output     serial data out of the chain
//
// Build option
//   SCAN_MSB_FIRST_EN  when defined, bits go out MSB-first and captured bits
//                      fill from bit DATA_W-1 downward. Default is LSB-first.
// -----------------------------------------------------------------------------
module scan_shift_engine #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              scan_enable,
  output logic              scan_ck_enable,
  output logic              scan_input,
  input  logic              scan_output
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    FLUSH,
    DONE
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   remaining;
  logic [IDX_W-1:0]   bit_idx;
  logic [DATA_W-1:0]  shift_reg;
  logic [DATA_W-1:0]  capture;
  logic [IDX_W-1:0]   cap_pos;
  logic               last_bit;

`ifdef SCAN_MSB_FIRST_EN
  assign scan_input = shift_reg[DATA_W-1];
  assign cap_pos    = IDX_W'(DATA_W - 1) - bit_idx;
`else
  assign scan_input = shift_reg[0];
  assign cap_pos    = bit_idx;
`endif

  // The current shift is the last one for this word either when the word is
  // full or when it consumes the final chain bit of the operation.
  assign last_bit = (bit_idx == IDX_W'(DATA_W - 1)) || (remaining == LEN_W'(1));

  // All outputs decode only from registers, so no input reaches an output
  // combinationally. Reset clears every register, which drives them all to 0.
  assign busy           = (state == LOAD) || (state == SHIFT) || (state == FLUSH);
  assign scan_enable    = busy;
  assign done           = (state == DONE);
  assign s_ready        = (state == LOAD);
  assign m_valid        = (state == FLUSH);
  assign scan_ck_enable = (state == SHIFT);
  assign m_data         = capture;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: the data registers are reset along with the control state so that a
  // reset mid-operation leaves no partial word visible on m_data or scan_input.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      state     <= IDLE;
      remaining <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      capture   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              remaining <= length;
              state     <= LOAD;
            end else begin
              state <= DONE;
            end
          end
        end

        LOAD: begin
          if (s_valid) begin
            shift_reg <= s_data;
            capture   <= '0;
            bit_idx   <= '0;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          // scan_output is sampled on the same edge that strobes the chain.
          capture[cap_pos] <= scan_output;
`ifdef SCAN_MSB_FIRST_EN
          shift_reg <= shift_reg << 1;
`else
          shift_reg <= shift_reg >> 1;
`endif
          remaining <= remaining - LEN_W'(1);
          bit_idx   <= bit_idx + IDX_W'(1);
          if (last_bit) begin
            state <= FLUSH;
          end
        end

        FLUSH: begin
          if (m_ready) begin
            state <= (remaining != '0) ? LOAD : DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_shift_engine.sv
// -----------------------------------------------------------------------------
// tb_scan_shift_engine
//
// Directed bench for scan_shift_engine. The chain side is selectable:
// loopback (scan_output = scan_input), a 128-bit shift-register chain, or a
// constant 1. Inputs change 1 time unit after the rising edge; a negedge
// monitor counts strobes, handshakes and pulses and logs the captured words.
// -----------------------------------------------------------------------------
module tb_scan_shift_engine;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic              aclk    = 1'b0;
  logic              aresetn = 1'b1;
  logic              start   = 1'b0;
  logic [LEN_W-1:0]  length  = '0;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] s_data  = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              scan_enable;
  logic              scan_ck_enable;
  logic              scan_input;
  logic              scan_output;

  always #5 aclk = ~aclk;

  scan_shift_engine #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .start          (start),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .scan_enable    (scan_enable),
    .scan_ck_enable (scan_ck_enable),
    .scan_input     (scan_input),
    .scan_output    (scan_output)
  );

  // Chain model: 0 = loopback, 1 = 128-bit shift register, 2 = constant 1.
  int           mode       = 0;
  logic         chain_load = 1'b0;
  logic [127:0] chain;

  always @(posedge aclk) begin
    if (chain_load)          chain <= '1;
    else if (scan_ck_enable) chain <= {scan_input, chain[127:1]};
  end

  always_comb begin
    scan_output = 1'b0;
    case (mode)
      0:       scan_output = scan_input;
      1:       scan_output = chain[0];
      default: scan_output = 1'b1;
    endcase
  end

  // Monitor: levels at the negedge equal the values seen by the next edge.
  int          ck_cnt     = 0;
  int          s_hs       = 0;
  int          m_hs       = 0;
  int          done_cnt   = 0;
  int          mvalid_cnt = 0;
  int          sready_cnt = 0;
  int          busy_cnt   = 0;
  logic [31:0] m_log  [0:15];
  logic        si_log [0:1023];

  always @(negedge aclk) begin
    if (scan_ck_enable) begin
      si_log[ck_cnt % 1024] = scan_input;
      ck_cnt++;
    end
    if (s_valid && s_ready) s_hs++;
    if (m_valid && m_ready) begin
      m_log[m_hs % 16] = m_data;
      m_hs++;
    end
    if (done)    done_cnt++;
    if (m_valid) mvalid_cnt++;
    if (s_ready) sready_cnt++;
    if (busy)    busy_cnt++;
  end

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // One complete operation: start, feed up to two words, optionally stall the
  // first output word for `stall` cycles, then check counts and words.
  task automatic run_op(input string tag, input logic [15:0] len,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input int stall, input int exp_words,
                        input logic [31:0] e0, input logic [31:0] e1);
    int ck0 = ck_cnt;
    int s0  = s_hs;
    int m0  = m_hs;
    int d0  = done_cnt;
    int left = 0;
    bit seen_mv = 1'b0;
    bit finished = 1'b0;
    s_data  = w0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    start   = 1'b1;
    length  = len;
    tick();
    start = 1'b0;
    for (int c = 0; c < 2000 && !finished; c++) begin
      s_data = (s_hs == s0) ? w0 : w1;
      if (m_valid && !seen_mv && stall > 0) begin
        seen_mv = 1'b1;
        left    = stall;
      end
      if (left > 0) begin
        m_ready = 1'b0;
        check({tag, " stalled m_data"}, m_data, e0);
        check({tag, " stalled scan_ck_enable"}, scan_ck_enable, 0);
        left--;
      end else begin
        m_ready = 1'b1;
      end
      if (done) finished = 1'b1;
      else      tick();
    end
    check({tag, " done reached"}, finished, 1);
    s_valid = 1'b0;
    tick();
    check({tag, " done one cycle"}, done, 0);
    check({tag, " idle after done"}, busy, 0);
    check({tag, " done pulses"}, done_cnt - d0, 1);
    check({tag, " shift strobes"}, ck_cnt - ck0, len);
    check({tag, " input words"}, s_hs - s0, exp_words);
    check({tag, " output words"}, m_hs - m0, exp_words);
    check({tag, " word0"}, m_log[m0 % 16], e0);
    if (exp_words > 1) check({tag, " word1"}, m_log[(m0 + 1) % 16], e1);
  endtask

  initial begin
    int base_ck, base_mv, base_sr, base_busy, base_m;
    bit reached;

    // Reset state while aresetn is held high.
    repeat (3) tick();
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst s_ready", s_ready, 0);
    check("rst m_valid", m_valid, 0);
    check("rst scan_enable", scan_enable, 0);
    check("rst scan_ck_enable", scan_ck_enable, 0);
    check("rst scan_input", scan_input, 0);
    check("rst m_data", m_data, 0);
    aresetn = 1'b0;
    tick();
    check("idle busy", busy, 0);

    // Loopback, one full word.
    mode    = 0;
    base_ck = ck_cnt;
    run_op("loop32", 16'd32, 32'hA5A50F0F, 32'h0, 0, 1, 32'hA5A50F0F, 32'h0);
    check("loop32 first scan_input", si_log[base_ck % 1024], 1);

    // 128-bit chain preloaded with ones, 40 bits across two words.
    chain_load = 1'b1;
    tick();
    chain_load = 1'b0;
    mode = 1;
    run_op("chain40", 16'd40, 32'h0, 32'h0, 0, 2, 32'hFFFFFFFF, 32'h000000FF);

    // Backpressure on the first output word for 10 cycles.
    mode = 0;
    run_op("stall64", 16'd64, 32'h12345678, 32'hCAFEF00D, 10, 2,
           32'h12345678, 32'hCAFEF00D);

    // Zero length goes straight to DONE.
    base_mv   = mvalid_cnt;
    base_sr   = sready_cnt;
    base_busy = busy_cnt;
    start  = 1'b1;
    length = 16'd0;
    tick();
    start = 1'b0;
    check("len0 done", done, 1);
    check("len0 busy", busy, 0);
    tick();
    check("len0 done one cycle", done, 0);
    check("len0 s_ready cycles", sready_cnt - base_sr, 0);
    check("len0 m_valid cycles", mvalid_cnt - base_mv, 0);
    check("len0 busy cycles", busy_cnt - base_busy, 0);

    // Reset after the 17th shift of a 32-bit operation.
    mode    = 0;
    base_ck = ck_cnt;
    base_mv = mvalid_cnt;
    base_m  = m_hs;
    reached = 1'b0;
    s_data  = 32'h3C3C55AA;
    s_valid = 1'b1;
    m_ready = 1'b1;
    start   = 1'b1;
    length  = 16'd32;
    tick();
    start = 1'b0;
    for (int c = 0; c < 200 && !reached; c++) begin
      if (ck_cnt - base_ck >= 17) reached = 1'b1;
      else                        tick();
    end
    check("rst17 shifts reached", ck_cnt - base_ck, 17);
    aresetn = 1'b1;
    #1;
    check("rst17 busy", busy, 0);
    check("rst17 done", done, 0);
    check("rst17 s_ready", s_ready, 0);
    check("rst17 m_valid", m_valid, 0);
    check("rst17 scan_enable", scan_enable, 0);
    check("rst17 scan_ck_enable", scan_ck_enable, 0);
    check("rst17 scan_input", scan_input, 0);
    check("rst17 m_data", m_data, 0);
    tick();
    tick();
    s_valid = 1'b0;
    aresetn = 1'b0;
    tick();
    check("rst17 no m_valid", mvalid_cnt - base_mv, 0);
    check("rst17 no output word", m_hs - base_m, 0);
    run_op("post_rst32", 16'd32, 32'hDEADBEEF, 32'h0, 0, 1, 32'hDEADBEEF, 32'h0);

    // Single bit with the chain returning a constant 1.
    mode    = 2;
    base_ck = ck_cnt;
`ifdef SCAN_MSB_FIRST_EN
    run_op("len1", 16'd1, 32'h80000000, 32'h0, 0, 1, 32'h80000000, 32'h0);
    check("len1 first scan_input", si_log[base_ck % 1024], 1);
`else
    run_op("len1", 16'd1, 32'h80000000, 32'h0, 0, 1, 32'h00000001, 32'h0);
    check("len1 first scan_input", si_log[base_ck % 1024], 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/scan_shift_engine.md
SCAN_SHIFT_ENGINE -- requirements
Module: scan_shift_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width of both streams.
REQ-002 SHALL have parameter LEN_W, default 16, width of the chain-length field in bits.
REQ-003 SHALL have port aclk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port aresetn  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a scan operation.
REQ-006 SHALL have port length  input  LEN_W  number of chain bits to shift, sampled on start.
REQ-007 SHALL have ports busy and done  output  1 each  operation in progress, and a one-cycle completion pulse.
REQ-008 SHALL have ports s_data, s_valid, s_ready  input DATA_W, input 1, output 1  snapshot words to inject, from the memory-read side.
REQ-009 SHALL have ports m_data, m_valid, m_ready  output DATA_W, output 1, input 1  captured words, to the memory-write side.
REQ-010 SHALL have ports scan_enable, scan_ck_enable, scan_input  output 1 each  chain mode, shift strobe, and serial data into the chain.
REQ-011 SHALL have port scan_output  input 1  serial data out of the chain.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, SHIFT, FLUSH and DONE.
REQ-013 IDLE: start with length!=0 SHALL latch length into a remaining-bit counter and go to LOAD; start with length==0 SHALL go to DONE with no stream activity.
REQ-014 start SHALL be ignored in every state other than IDLE.
REQ-015 LOAD: s_ready SHALL be 1; an s_valid&&s_ready handshake SHALL load the shift register, clear the capture register and bit index, and go to SHIFT.
REQ-016 SHIFT: scan_ck_enable SHALL be 1 on every SHIFT cycle; scan_input SHALL equal the current LSB of the shift register, which then shifts right by one.
REQ-017 SHALL sample scan_output in the same cycle scan_ck_enable is 1 and store it at capture bit index i (LSB-first).
REQ-018 Each SHIFT cycle SHALL decrement the remaining counter; after DATA_W bits, or when remaining reaches 0, the FSM SHALL go to FLUSH.
REQ-019 FLUSH: m_valid SHALL be 1 and m_data SHALL be the capture register, held stable until m_ready; capture bits never written SHALL be 0.
REQ-020 On the FLUSH handshake SHALL go to LOAD if remaining>0, else to DONE.
REQ-021 scan_ck_enable SHALL be 0 outside SHIFT, so backpressure on m_ready or starvation on s_valid stalls the chain without losing bits.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 busy SHALL be 1 in LOAD, SHIFT and FLUSH; scan_enable SHALL equal busy.
REQ-024 Number of input words consumed and output words produced SHALL each equal ceil(length/DATA_W).

Reset
REQ-025 aresetn=1 SHALL immediately force IDLE and clear all counters and data registers.
REQ-026 During reset, busy, done, s_ready, m_valid, scan_enable, scan_ck_enable and scan_input SHALL be 0, and m_data SHALL be 0.
REQ-027 Reset mid-operation SHALL discard any partial word, and the next start SHALL behave as after power-up.

Configuration
REQ-028 With macro SCAN_MSB_FIRST_EN defined, scan_input SHALL take the shift-register MSB, the register SHALL shift left, and capture SHALL fill from bit DATA_W-1 downward (the unused low bits of a partial word are 0).
REQ-029 Without SCAN_MSB_FIRST_EN, ordering SHALL be LSB-first as in REQ-016/REQ-017.

Verification
REQ-030 scan_output tied to scan_input, length=32, s_data=0xA5A50F0F, m_ready=1 -> exactly 32 scan_ck_enable cycles, one output word m_data=0xA5A50F0F, then done pulse.
REQ-031 128-bit shift-register chain model preloaded to all ones, length=40, s_data=0 twice -> m_data 0xFFFFFFFF then 0x000000FF, two s handshakes, one done.
REQ-032 length=64 with m_ready held 0 for 10 cycles after the first m_valid -> m_data stable, scan_ck_enable=0 for those cycles, second word correct.
REQ-033 start with length=0 -> done=1 in the next cycle, s_ready and m_valid never asserted, busy stays 0.
REQ-034 aresetn pulsed after the 17th shift of a 32-bit operation -> all outputs 0 at once, no m_valid; a new start with length=32 completes correctly.
REQ-035 SCAN_MSB_FIRST_EN defined, length=1, s_data=0x80000000, scan_output=1 -> first scan_input=1, m_data=0x80000000.
